// File: rtl/decode_pkg.sv
// Shared opcodes, instruction field positions, FSM states and the issue packet
// for the decode/register-read stage.
package decode_pkg;

  localparam logic [6:0] OPC_ADD = 7'h00;
  localparam logic [6:0] OPC_SUB = 7'h01;
  localparam logic [6:0] OPC_MUL = 7'h02;
  localparam logic [6:0] OPC_NOP = 7'h3F;

  localparam int OPC_MSB = 31, OPC_LSB = 25;
  localparam int DST_MSB = 24, DST_LSB = 20;
  localparam int RS1_MSB = 19, RS1_LSB = 15;
  localparam int RS2_MSB = 14, RS2_LSB = 10;
  localparam int OFF_MSB = 9,  OFF_LSB = 0;

  typedef enum logic {ISSUE = 1'b0, MUL_HOLD = 1'b1} state_e;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  dst;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [9:0]  offsetlo;
  } ex_pkt_t;

  localparam ex_pkt_t EX_BUBBLE = '{opcode: OPC_NOP, dst: 5'd0, src1: 32'd0,
                                    src2: 32'd0, offsetlo: 10'd0};

  function automatic logic is_writer(input logic [6:0] opc);
    return (opc == OPC_ADD) || (opc == OPC_SUB) || (opc == OPC_MUL);
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// 32x32 register file, two async read ports, one write port, r0 reads zero.
// With DECODE_WB_BYPASS_EN defined, a same-cycle writeback is forwarded to reads.
module decode_regfile
  import decode_pkg::*;
#(
  parameter bit RF_RESET = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o
);

  logic [31:0] mem_q [32];
  logic        byp1, byp2;

  generate
    if (RF_RESET) begin : g_rst
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          for (int i = 0; i < 32; i++) mem_q[i] <= '0;
        end else if (we_i && waddr_i != 5'd0) begin
          mem_q[waddr_i] <= wdata_i;
        end
      end
    end else begin : g_nrst
      always_ff @(posedge clk_i) begin
        if (we_i && waddr_i != 5'd0) mem_q[waddr_i] <= wdata_i;
      end
    end
  endgenerate

`ifdef DECODE_WB_BYPASS_EN
  assign byp1 = we_i && (waddr_i == raddr1_i);
  assign byp2 = we_i && (waddr_i == raddr2_i);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  assign rdata1_o = (raddr1_i == 5'd0) ? 32'd0 : byp1 ? wdata_i : mem_q[raddr1_i];
  assign rdata2_o = (raddr2_i == 5'd0) ? 32'd0 : byp2 ? wdata_i : mem_q[raddr2_i];

endmodule

// File: rtl/decode_stage.sv
// Decode/register-read stage: RAW scoreboard, MUL hold FSM, registered ex_* outputs.
// Optional macro DECODE_WB_BYPASS_EN forwards writeback data and clears its hazard.
module decode_stage
  import decode_pkg::*;
#(
  parameter int MUL_LAT  = 5,
  parameter bit RF_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  output logic        stall_o,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic [6:0]  ex_opcode,
  output logic [4:0]  ex_dst,
  output logic [31:0] ex_src1,
  output logic [31:0] ex_src2,
  output logic [9:0]  ex_offsetlo
);

  logic [6:0]  opc;
  logic [4:0]  dst, rs1, rs2;
  logic [9:0]  off;
  logic [31:0] rd1, rd2;
  logic [31:0] pend_q, pend_d, pend_eff;
  logic [2:0]  cnt_q, cnt_d;
  logic        hazard, accept;
  state_e      state_q, state_d;
  ex_pkt_t     ex_q, ex_d;

  assign opc = if_instr[OPC_MSB:OPC_LSB];
  assign dst = if_instr[DST_MSB:DST_LSB];
  assign rs1 = if_instr[RS1_MSB:RS1_LSB];
  assign rs2 = if_instr[RS2_MSB:RS2_LSB];
  assign off = if_instr[OFF_MSB:OFF_LSB];

  decode_regfile #(.RF_RESET(RF_RESET)) u_rf (
    .clk_i(clk), .rst_i(rst),
    .we_i(wb_en), .waddr_i(wb_addr), .wdata_i(wb_data),
    .raddr1_i(rs1), .raddr2_i(rs2),
    .rdata1_o(rd1), .rdata2_o(rd2)
  );

  // A register being written back this cycle no longer blocks when bypass is on.
  always_comb begin
    pend_eff = pend_q;
`ifdef DECODE_WB_BYPASS_EN
    if (wb_en) pend_eff[wb_addr] = 1'b0;
`endif
  end

  assign hazard = if_valid & (((rs1 != 5'd0) & pend_eff[rs1]) |
                              ((rs2 != 5'd0) & pend_eff[rs2]));
  assign accept = (state_q == ISSUE) & if_valid & ~hazard;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ISSUE;
      cnt_q   <= 3'd0;
      pend_q  <= '0;
      ex_q    <= EX_BUBBLE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ex_q    <= ex_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ISSUE: if (accept && opc == OPC_MUL) begin
        state_d = MUL_HOLD;
        cnt_d   = 3'(MUL_LAT - 1);
      end
      MUL_HOLD: if (cnt_q == 3'd1) begin
        state_d = ISSUE;
        cnt_d   = 3'd0;
      end else begin
        cnt_d = cnt_q - 3'd1;
      end
      default: state_d = ISSUE;
    endcase
  end

  // Set beats clear when the issued writer targets the register being written back.
  always_comb begin
    stall_o = (state_q == MUL_HOLD) | hazard;
    ex_d    = (state_q == MUL_HOLD) ? ex_q : EX_BUBBLE;
    pend_d  = pend_q;
    if (wb_en) pend_d[wb_addr] = 1'b0;
    if (accept) begin
      ex_d = '{opcode: opc, dst: dst, src1: rd1, src2: rd2, offsetlo: off};
      if (is_writer(opc) && dst != 5'd0) pend_d[dst] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  assign ex_opcode   = ex_q.opcode;
  assign ex_dst      = ex_q.dst;
  assign ex_src1     = ex_q.src1;
  assign ex_src2     = ex_q.src2;
  assign ex_offsetlo = ex_q.offsetlo;

endmodule

// File: tb/tb_decode_stage.sv
// Randomised scoreboard bench for decode_stage against a cycle-level reference model.
module tb_decode_stage;

  localparam int MUL_LAT = 5;
`ifdef DECODE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [6:0]  opc;
    logic [4:0]  dst;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [9:0]  off;
  } exp_t;

  logic        clk, rst, if_valid, stall_o, wb_en;
  logic [31:0] if_instr, wb_data, ex_src1, ex_src2;
  logic [4:0]  wb_addr, ex_dst;
  logic [6:0]  ex_opcode;
  logic [9:0]  ex_offsetlo;

  decode_stage #(.MUL_LAT(MUL_LAT), .RF_RESET(1'b1)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .stall_o(stall_o),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_opcode(ex_opcode), .ex_dst(ex_dst), .ex_src1(ex_src1), .ex_src2(ex_src2),
    .ex_offsetlo(ex_offsetlo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // reference model state
  logic [31:0] m_rf [32];
  bit          m_pend [32];
  int          m_hold;
  exp_t        m_ex;
  exp_t        q [$];

  localparam exp_t BUBBLE = '{opc: 7'h3F, dst: 5'd0, s1: 32'd0, s2: 32'd0, off: 10'd0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mread(input logic [4:0] a, input logic we,
                                        input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
    if (BYP && we && wa == a) return wd;
    return m_rf[a];
  endfunction

  function automatic bit mpend(input logic [4:0] a, input logic we, input logic [4:0] wa);
    return (a != 5'd0) && m_pend[a] && !(BYP && we && wa == a);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin m_rf[i] = 32'd0; m_pend[i] = 1'b0; end
    m_hold = 0;
    m_ex = BUBBLE;
    q.delete();
  endtask

  function automatic logic [31:0] mk(input int opc, input int d, input int r1, input int r2,
                                     input int off);
    logic [31:0] w;
    w = {opc[6:0], d[4:0], r1[4:0], r2[4:0], off[9:0]};
    return w;
  endfunction

  // One cycle: drive inputs, predict, check stall, queue the expected ex_* after the edge.
  task automatic step(input logic v, input logic [31:0] ins, input logic we,
                      input logic [4:0] wa, input logic [31:0] wd, output bit stalled);
    bit exp_stall, acc;
    logic [6:0] opc;
    logic [4:0] d, r1, r2;
    @(negedge clk);
    if_valid = v; if_instr = ins; wb_en = we; wb_addr = wa; wb_data = wd;
    #1;
    opc = ins[31:25]; d = ins[24:20]; r1 = ins[19:15]; r2 = ins[14:10];
    acc = 1'b0;
    if (m_hold > 0) begin
      exp_stall = 1'b1;
      m_hold--;
    end else begin
      exp_stall = v && (mpend(r1, we, wa) || mpend(r2, we, wa));
      acc = v && !exp_stall;
      if (acc) begin
        m_ex = '{opc: opc, dst: d, s1: mread(r1, we, wa, wd), s2: mread(r2, we, wa, wd),
                 off: ins[9:0]};
        if (opc == 7'h02) m_hold = MUL_LAT - 1;
      end else begin
        m_ex = BUBBLE;
      end
    end
    if (we && wa != 5'd0) m_rf[wa] = wd;
    if (we) m_pend[wa] = 1'b0;
    if (acc && opc <= 7'h02 && d != 5'd0) m_pend[d] = 1'b1;
    chk("stall_o", {31'd0, stall_o}, {31'd0, exp_stall});
    q.push_back(m_ex);
    stalled = exp_stall;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; if_valid = 1'b0; wb_en = 1'b0;
    #1;
    chk("rst_opcode", {25'd0, ex_opcode}, 32'h3F);
    chk("rst_fields", ex_src1 | ex_src2 | {22'd0, ex_offsetlo} | {27'd0, ex_dst}, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // monitor: every cycle with an outstanding expectation, compare ex_*
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ex_opcode", {25'd0, ex_opcode}, {25'd0, e.opc});
        chk("ex_dst", {27'd0, ex_dst}, {27'd0, e.dst});
        chk("ex_src1", ex_src1, e.s1);
        chk("ex_src2", ex_src2, e.s2);
        chk("ex_offsetlo", {22'd0, ex_offsetlo}, {22'd0, e.off});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] rnd_instr();
    int opc;
    case ($urandom_range(0, 5))
      0: opc = 7'h00;
      1: opc = 7'h01;
      2: opc = 7'h02;
      3: opc = 7'h3F;
      4: opc = 7'h05;
      default: opc = int'($urandom_range(0, 127));
    endcase
    return mk(opc, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 1023));
  endfunction

  initial begin
    bit st;
    int nst;
    logic [31:0] ins;
    logic v, we;
    logic [4:0] wa;
    rst = 1'b1; if_valid = 1'b0; if_instr = '0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    // idle after reset
    repeat (4) step(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, st);

    // ADD with operands from writeback
    step(1'b0, 32'd0, 1'b1, 5'd1, 32'd5, st);
    step(1'b0, 32'd0, 1'b1, 5'd2, 32'd7, st);
    step(1'b1, mk(7'h00, 3, 1, 2, 10'h155), 1'b0, 5'd0, 32'd0, st);

    // RAW on r3, released by a writeback of 9 on the third try
    for (int i = 0; i < 10; i++) begin
      step(1'b1, mk(7'h01, 5, 3, 0, 10'h0AA), (i == 2), 5'd3, 32'd9, st);
      if (!st) break;
    end

    // MUL hold, then an ADD waiting on fetch
    step(1'b1, mk(7'h02, 4, 1, 2, 10'h011), 1'b0, 5'd0, 32'd0, st);
    nst = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, mk(7'h00, 6, 0, 0, 10'h022), (i == 1), 5'd1, 32'h1234, st);
      if (stall_o) nst++;
      if (!st) break;
    end
    chk("mul_stall_cycles", nst, MUL_LAT - 1);

    // r0 rules
    step(1'b0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, st);
    step(1'b1, mk(7'h00, 0, 0, 0, 10'h3FF), 1'b0, 5'd0, 32'd0, st);
    step(1'b1, mk(7'h01, 8, 0, 0, 10'h001), 1'b0, 5'd0, 32'd0, st);

    // reset two cycles into a MUL hold
    step(1'b1, mk(7'h02, 7, 1, 2, 10'h033), 1'b0, 5'd0, 32'd0, st);
    repeat (2) step(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, st);
    do_reset();
    step(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, st);
    step(1'b1, mk(7'h00, 9, 7, 4, 10'h044), 1'b0, 5'd0, 32'd0, st);
    step(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, st);

    // randomised traffic; fetch holds its instruction while stalled
    v = 1'b0; ins = '0;
    for (int n = 0; n < 2000; n++) begin
      if (!st) begin
        v = ($urandom_range(0, 3) != 0);
        ins = rnd_instr();
      end
      we = ($urandom_range(0, 2) == 0);
      wa = 5'($urandom_range(0, 7));
      step(v, ins, we, wa, $urandom, st);
    end
    step(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, st);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
